// File: rtl/serial_twos_comp_mc_if.sv
// Bit-serial bus for serial_twos_comp_mc: lane data, framing and per-lane result flags.
interface serial_twos_comp_mc_if #(
  parameter int CHANNELS = 2
);
  logic                in_valid;
  logic                sof;
  logic [CHANNELS-1:0] neg;
  logic [CHANNELS-1:0] i;
  logic [CHANNELS-1:0] y;
  logic                out_valid;
  logic                out_last;
  logic [CHANNELS-1:0] ovf;

  modport master (output in_valid, sof, neg, i, input  y, out_valid, out_last, ovf);
  modport slave  (input  in_valid, sof, neg, i, output y, out_valid, out_last, ovf);
endinterface

// File: rtl/serial_twos_comp_mc.sv
// Multi-lane LSB-first serial two's complementer with shared word framing.
// Each lane passes bits up to and including its first 1, then inverts the rest.
module serial_twos_comp_mc_lane (
  input  logic t_clk,
  input  logic r,
  input  logic acc,
  input  logic pos0,
  input  logic last,
  input  logic neg,
  input  logic i,
  output logic y,
  output logic ovf
);
  logic seen, neg_q;
  logic eff_neg, s;

  always_comb begin
    eff_neg = pos0 ? neg : neg_q;
    s       = pos0 ? 1'b0 : seen;
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      y     <= 1'b0;
      ovf   <= 1'b0;
      seen  <= 1'b0;
      neg_q <= 1'b0;
    end else if (acc) begin
      y     <= i ^ (eff_neg & s);
      seen  <= last ? 1'b0 : (s | i);
      ovf   <= last & eff_neg & ~s & i;
      if (pos0) neg_q <= neg;
    end else begin
      ovf <= 1'b0;
    end
  end
endmodule

module serial_twos_comp_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                  t_clk,
  input  logic                  r,
  serial_twos_comp_mc_if.slave  bus
);
  localparam int             CW       = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_POS = CW'(WIDTH - 1);

  logic [CW-1:0] bit_cnt, pos;
  logic          pos0, last;
  logic          vld_pipe;

  // sof only realigns framing on an accepted slot; a stalled sof is ignored
  always_comb begin
    pos  = (bus.in_valid & bus.sof) ? '0 : bit_cnt;
    pos0 = (pos == '0);
    last = (pos == LAST_POS);
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      bit_cnt      <= '0;
      vld_pipe     <= 1'b0;
      bus.out_last <= 1'b0;
    end else begin
      vld_pipe     <= bus.in_valid;
      bus.out_last <= bus.in_valid & last;
      if (bus.in_valid) bit_cnt <= last ? '0 : pos + CW'(1);
    end
  end

  assign bus.out_valid = vld_pipe;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    serial_twos_comp_mc_lane u_lane (
      .t_clk (t_clk),
      .r     (r),
      .acc   (bus.in_valid),
      .pos0  (pos0),
      .last  (last),
      .neg   (bus.neg[c]),
      .i     (bus.i[c]),
      .y     (bus.y[c]),
      .ovf   (bus.ovf[c])
    );
  end
endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Directed + randomized bench; expected bits come from whole-word arithmetic negation.
module tb_serial_twos_comp_mc;
  logic t_clk = 1'b0;
  logic r;
  int   total  = 0;
  int   passed = 0;

  always #5 t_clk = ~t_clk;

  serial_twos_comp_mc_if #(.CHANNELS(2)) bus ();
  serial_twos_comp_mc #(.WIDTH(8), .CHANNELS(2)) dut (.t_clk(t_clk), .r(r), .bus(bus));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives nbits bits of a word per lane; expected output is the full-word
  // result (x or -x mod 256), whose low bits are fixed once those input bits are known.
  task automatic send_word(input logic [7:0] x0, input logic [7:0] x1, input logic [1:0] n,
                           input logic use_sof, input int nbits,
                           input int stall_after, input int stall_len);
    logic [7:0] r0, r1;
    logic [1:0] eovf;
    r0   = n[0] ? 8'(-x0) : x0;
    r1   = n[1] ? 8'(-x1) : x1;
    eovf = {n[1] && x1 == 8'h80, n[0] && x0 == 8'h80};
    for (int k = 0; k < nbits; k++) begin
      @(negedge t_clk);
      bus.in_valid = 1'b1;
      bus.sof      = (k == 0) ? use_sof : 1'b0;
      bus.neg      = (k == 0) ? n : 2'($urandom);
      bus.i        = {x1[k], x0[k]};
      @(posedge t_clk); #1;
      chk("out_valid", 8'(bus.out_valid), 8'd1);
      chk("y",         8'(bus.y), 8'({r1[k], r0[k]}));
      chk("out_last",  8'(bus.out_last), 8'(k == 7));
      chk("ovf",       8'(bus.ovf), (k == 7) ? 8'(eovf) : 8'd0);
      if (k == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge t_clk);
          bus.in_valid = 1'b0;
          bus.sof      = 1'($urandom);
          bus.neg      = 2'($urandom);
          bus.i        = 2'($urandom);
          @(posedge t_clk); #1;
          chk("stall_valid", 8'(bus.out_valid), 8'd0);
          chk("stall_last",  8'(bus.out_last), 8'd0);
          chk("stall_ovf",   8'(bus.ovf), 8'd0);
          chk("stall_y",     8'(bus.y), 8'({r1[k], r0[k]}));
        end
      end
    end
  endtask

  initial begin
    logic [7:0] x0, x1;
    logic [1:0] n;
    logic       need_sof;
    int         nb, sa;

    r = 1'b1;
    bus.in_valid = 1'b0; bus.sof = 1'b0; bus.neg = '0; bus.i = '0;
    #12;
    chk("rst_y",     8'(bus.y), 8'd0);
    chk("rst_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_last",  8'(bus.out_last), 8'd0);
    chk("rst_ovf",   8'(bus.ovf), 8'd0);
    @(negedge t_clk); r = 1'b0;
    @(posedge t_clk); #1;
    chk("post_rst_valid", 8'(bus.out_valid), 8'd0);
    chk("post_rst_y",     8'(bus.y), 8'd0);

    send_word(8'h06, 8'h5A, 2'b01, 1'b1, 8, -1, 0);   // basic negate / pass
    send_word(8'h80, 8'h00, 2'b11, 1'b1, 8, -1, 0);   // most-negative and zero
    send_word(8'h01, 8'h01, 2'b11, 1'b1, 8, -1, 0);   // back-to-back, no gap
    send_word(8'hFF, 8'hFF, 2'b11, 1'b0, 8, -1, 0);
    send_word(8'h06, 8'h5A, 2'b01, 1'b0, 8, 3, 3);    // stall after bit 3
    send_word(8'h3C, 8'hC3, 2'b10, 1'b0, 5, -1, 0);   // aborted at bit 5
    send_word(8'h80, 8'h14, 2'b01, 1'b1, 8, -1, 0);   // fresh word via sof
    send_word(8'h22, 8'h80, 2'b10, 1'b0, 8, -1, 0);   // framing realigned
    send_word(8'h00, 8'h00, 2'b00, 1'b1, 8, -1, 0);   // sof at bit 0 (no-op)

    // asynchronous reset between edges, mid-word
    send_word(8'h55, 8'hAA, 2'b11, 1'b0, 3, -1, 0);
    #2 r = 1'b1;
    #1;
    chk("mid_rst_y",     8'(bus.y), 8'd0);
    chk("mid_rst_valid", 8'(bus.out_valid), 8'd0);
    bus.in_valid = 1'b0;
    @(negedge t_clk); r = 1'b0;
    @(posedge t_clk); #1;
    chk("mid_rst_post_valid", 8'(bus.out_valid), 8'd0);
    send_word(8'h28, 8'h80, 2'b11, 1'b0, 8, -1, 0);

    need_sof = 1'b0;
    for (int w = 0; w < 30; w++) begin
      x0 = 8'($urandom); x1 = 8'($urandom);
      if ($urandom_range(0, 4) == 0) x0 = 8'h80;
      if ($urandom_range(0, 4) == 0) x1 = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
      n  = 2'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 8;
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_word(x0, x1, n, need_sof | 1'($urandom), nb, sa, int'($urandom_range(1, 3)));
      need_sof = (nb != 8);
    end

    @(negedge t_clk); bus.in_valid = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
